// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared state encoding and default parameters for the APB master
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_SLV = 4;
    localparam int DEF_TIMEOUT = 256;

endpackage

// File: rtl/apb_wdog_cnt.sv
// rtl/apb_wdog_cnt.sv - ACCESS-phase cycle counter; expired marks the last permitted cycle
module apb_wdog_cnt #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // cnt_q holds the number of ACCESS cycles already completed, so the
    // current cycle is the limit-th one when cnt_q == limit-1; limit 0 disables.
    assign expired = enable && (limit != '0) && (cnt_q == limit - W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_gen.sv
// rtl/apb_master_gen.sv - single-outstanding APB4 master with slave decode and ACCESS timeout
module apb_master_gen
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_SLV = DEF_NUM_SLV,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_strb,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int SEL_W  = $clog2(NUM_SLV);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e          state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic                wd_clear;
    logic                wd_enable;
    logic                wd_expired;
    logic [SEL_W-1:0]    req_idx;
    logic [DATA_W-1:0]   sel_rdata;

    assign req_idx   = req_addr[ADDR_W-1 -: SEL_W];
    assign sel_rdata = prdata[idx_q*DATA_W +: DATA_W];

    apb_wdog_cnt #(
        .W (CNT_W)
    ) u_wdog (
        .clk     (pclk),
        .rst_n   (presetn),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (CNT_W'(TIMEOUT)),
        .expired (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_clear      = 1'b0;
        wd_enable     = 1'b0;
        req_ready     = (state_q == ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_SETUP;
                    idx_d    = req_idx;
                    psel_d   = NUM_SLV'(1) << req_idx;
                    pwrite_d = req_write;
                    paddr_d  = req_addr;
                    pwdata_d = req_write ? req_wdata : '0;
                    pstrb_d  = req_write ? req_strb : '0;
                    wd_clear = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                wd_enable = 1'b1;
                // A pready on the limit cycle still counts as a normal completion.
                if (pready[idx_q]) begin
                    state_d       = ST_IDLE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : sel_rdata;
                    rsp_err_d     = pslverr[idx_q];
                    rsp_timeout_d = 1'b0;
                end else if (wd_expired) begin
                    state_d       = ST_IDLE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/apb_master_gen.md
APB_MASTER_GEN -- requirements
Module: apb_master_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning APB address width (16..32).
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width (8, 16 or 32).
REQ-003 SHALL have parameter NUM_SLV, default 4, meaning slave count (power of two, 2..16); SEL_W = log2(NUM_SLV).
REQ-004 SHALL have parameter TIMEOUT, default 256, meaning maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-005 SHALL have port pclk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port presetn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports req_valid (input, 1), req_ready (output, 1), req_write (input, 1), req_addr (input, ADDR_W), req_wdata (input, DATA_W), req_strb (input, DATA_W/8): request channel.
REQ-008 SHALL have ports rsp_valid (output, 1), rsp_rdata (output, DATA_W), rsp_err (output, 1), rsp_timeout (output, 1): response channel.
REQ-009 SHALL have ports psel (output, NUM_SLV, one-hot), penable (output, 1), pwrite (output, 1), paddr (output, ADDR_W), pwdata (output, DATA_W), pstrb (output, DATA_W/8): APB4 request.
REQ-010 SHALL have ports prdata (input, NUM_SLV*DATA_W, slave i at bits [i*DATA_W +: DATA_W]), pready (input, NUM_SLV), pslverr (input, NUM_SLV): APB4 completion.

Function
REQ-011 SHALL implement the states IDLE, SETUP and ACCESS; every output SHALL be registered except req_ready.
REQ-012 SHALL drive req_ready = 1 only in IDLE; a request is accepted on a pclk edge where req_valid && req_ready.
REQ-013 On acceptance, SHALL latch write, address, wdata and strb, decode slave index = req_addr[ADDR_W-1 -: SEL_W], and enter SETUP.
REQ-014 In SETUP, SHALL drive psel[index] = 1 and penable = 0 for exactly one cycle, then enter ACCESS.
REQ-015 In ACCESS, SHALL drive penable = 1 and keep psel, paddr, pwrite, pwdata and pstrb stable until completion.
REQ-016 SHALL drive pwdata and pstrb to zero for reads.
REQ-017 SHALL sample only pready[index], pslverr[index] and the prdata slice of the selected slave; other slaves' inputs SHALL be ignored.
REQ-018 When pready[index] = 1 in ACCESS, SHALL return to IDLE, clear psel and penable, and pulse rsp_valid for one cycle with rsp_err = pslverr[index] and rsp_timeout = 0.
REQ-019 On completion, SHALL set rsp_rdata = prdata slice for reads and zero for writes.
REQ-020 Minimum latency SHALL be: accept at edge k, SETUP after edge k, ACCESS after edge k+1, rsp_valid after edge k+2 (3 cycles per transfer).
REQ-021 SHALL allow back-to-back transfers: a request accepted in the same cycle rsp_valid is high enters SETUP next.
REQ-022 The ACCESS cycle counter SHALL reset on SETUP entry.
REQ-023 When TIMEOUT > 0 and the counter reaches TIMEOUT without pready, SHALL abort to IDLE with rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, and rsp_rdata = 0.
REQ-024 If pready arrives on the same cycle the limit is reached, SHALL treat it as a normal completion.
REQ-025 rsp_rdata, rsp_err and rsp_timeout SHALL hold their values until the next completion; rsp_valid SHALL be a single-cycle pulse.

Reset
REQ-026 presetn low SHALL asynchronously force state IDLE and zero every registered output: psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, and the counter.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer with no rsp_valid; the first accept is possible one cycle after presetn deasserts.

Structure
REQ-028 Package apb_master_pkg SHALL hold the state enum and the default parameter constants.
REQ-029 The timeout counter SHALL be a sub-module apb_wdog_cnt (inputs clear, enable, limit; output expired).

Verification
REQ-030 Write, addr 0x4000_0010, NUM_SLV=4, pready tied 1 -> psel = 4'b0010, pstrb = 4'hF, penable high one cycle, rsp_valid 3 cycles after accept, rsp_err = 0.
REQ-031 Read slave 3 (addr 0xC000_0000), prdata slice = 0xDEAD_BEEF, pready delayed 5 cycles -> inputs stable across waits; rsp_rdata = 0xDEAD_BEEF after 8 cycles.
REQ-032 pslverr[1] = 1 with pready -> rsp_err = 1, rsp_timeout = 0; toggling other slaves' pready has no effect.
REQ-033 TIMEOUT = 16, pready held 0 -> abort after 16 ACCESS cycles with rsp_err = rsp_timeout = 1 and psel cleared; a second case with pready on cycle 16 completes normally.
REQ-034 Back-to-back reads with req_valid constant, plus presetn pulsed mid-ACCESS -> transfer every 3 cycles; reset zeroes outputs immediately, no rsp_valid, and the next accept succeeds.
